// File: rtl/clk_meas_pkg.sv
// clk_meas_pkg: state encoding and shared constants for the clock period meter.
package clk_meas_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam int CNT_W_DEFAULT = 28;

  localparam int AVG_DEPTH = 4;
  localparam int AVG_SHIFT = $clog2(AVG_DEPTH);

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer for an asynchronous pin plus
// single-cycle rise/fall strobes on the synchronized level.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_in,
  input  logic reset,
  input  logic async_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow input in clock_in cycles.
// Define CLK_PERIOD_METER_AVG_EN to report the average of every 4 periods instead.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             signal_in,
  output logic [CNT_W-1:0] period_count,
  output logic [CNT_W-1:0] high_count,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic             sig_s_unused;
  logic             rise;
  logic             fall;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             timeout_q, timeout_d;
  logic             upd_q, upd_d;
  logic             valid_q;
  logic             res_stb;
  logic             tmo_stb;
  logic             avg_clr;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .async_in (signal_in),
    .s        (sig_s_unused),
    .rise     (rise),
    .fall     (fall)
  );

  // Measurement FSM: cnt is 1 in the cycle after a rise, so at the next rise it equals the period.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    timeout_d = timeout_q;
    res_stb   = 1'b0;
    tmo_stb   = 1'b0;
    cnt_inc   = sat_inc(cnt_q);
    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      hi_d      = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          hi_d  = '0;
          if (rise) begin
            state_d = ST_MEASURE;
            cnt_d   = CNT_ONE;
          end
        end
        ST_MEASURE: begin
          if (fall) hi_d = cnt_q;
          if (rise) begin
            res_stb = 1'b1;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d   = ST_TIMEOUT;
              timeout_d = 1'b1;
              tmo_stb   = 1'b1;
            end
          end
        end
        ST_TIMEOUT: begin
          if (fall) hi_d = cnt_q;
          if (rise) begin
            state_d   = ST_MEASURE;
            cnt_d     = CNT_ONE;
            timeout_d = 1'b0;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          hi_d      = '0;
          timeout_d = 1'b0;
        end
      endcase
    end
  end

  assign avg_clr = ~enable | tmo_stb;

`ifdef CLK_PERIOD_METER_AVG_EN
  localparam int ACC_W = CNT_W + AVG_SHIFT;
  localparam logic [AVG_SHIFT-1:0] AVG_LAST = AVG_SHIFT'(AVG_DEPTH - 1);

  logic [ACC_W-1:0]     acc_p_q, acc_p_d, acc_h_q, acc_h_d;
  logic [ACC_W-1:0]     sum_p, sum_h;
  logic [AVG_SHIFT-1:0] phase_q, phase_d;

  // Result stage: accumulate AVG_DEPTH periods, publish the truncated mean on the last one.
  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    upd_d    = 1'b0;
    acc_p_d  = acc_p_q;
    acc_h_d  = acc_h_q;
    phase_d  = phase_q;
    sum_p    = acc_p_q + {{AVG_SHIFT{1'b0}}, cnt_q};
    sum_h    = acc_h_q + {{AVG_SHIFT{1'b0}}, hi_q};
    if (tmo_stb) begin
      period_d = '0;
      high_d   = '0;
    end
    if (avg_clr) begin
      acc_p_d = '0;
      acc_h_d = '0;
      phase_d = '0;
    end else if (res_stb) begin
      if (phase_q == AVG_LAST) begin
        period_d = sum_p[ACC_W-1:AVG_SHIFT];
        high_d   = sum_h[ACC_W-1:AVG_SHIFT];
        upd_d    = 1'b1;
        acc_p_d  = '0;
        acc_h_d  = '0;
        phase_d  = '0;
      end else begin
        acc_p_d = sum_p;
        acc_h_d = sum_h;
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      acc_p_q <= '0;
      acc_h_q <= '0;
      phase_q <= '0;
    end else begin
      acc_p_q <= acc_p_d;
      acc_h_q <= acc_h_d;
      phase_q <= phase_d;
    end
  end
`else
  // Result stage: publish every period; outputs read zero while timed out.
  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    upd_d    = 1'b0;
    if (tmo_stb) begin
      period_d = '0;
      high_d   = '0;
    end else if (res_stb) begin
      period_d = cnt_q;
      high_d   = hi_q;
      upd_d    = 1'b1;
    end
  end

  logic avg_clr_unused;
  assign avg_clr_unused = avg_clr;
`endif

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      period_q  <= '0;
      high_q    <= '0;
      timeout_q <= 1'b0;
      upd_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      period_q  <= period_d;
      high_q    <= high_d;
      timeout_q <= timeout_d;
      upd_q     <= upd_d;
      valid_q   <= upd_q;
    end
  end

  assign period_count = period_q;
  assign high_count   = high_q;
  assign meas_valid   = valid_q;
  assign timeout      = timeout_q;

endmodule
